muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer. Owns the HI/LO architectural registers and executes MULT, MULTU, DIV and DIVU issued from decode.
- Sits beside the execute stage. Its Busy output feeds the pipeline stall logic so decode holds dependent instructions.
- One shared radix-2 datapath is sequenced by an FSM: 32 iterations plus one sign-fixup cycle.

---
 rtl/muldiv_seq_pkg.sv | 25 ++
 rtl/muldiv_seq_md_iter.sv | 34 +++
 rtl/muldiv_seq.sv | 121 ++++++++++++
 tb/tb_muldiv_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared constants, state encoding and helpers for the multiply/divide sequencer.
package muldiv_seq_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;
  localparam int DW    = 2 * WIDTH;

  // Bit positions inside the decode control word used to derive Start/IsDiv/Unsigned.
  localparam int OP_MULT     = 0;
  localparam int OP_DIV      = 1;
  localparam int OP_UNSIGNED = 2;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [WIDTH-1:0] md_abs(input logic [WIDTH-1:0] v,
                                              input logic             is_signed);
    return (is_signed && v[WIDTH-1]) ? ((~v) + WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/muldiv_seq_md_iter.sv
// Single radix-2 iteration of the shared multiply/divide datapath.
// Multiply: acc = {partial_hi, multiplier}; LSB of the multiplier is consumed first.
// Divide:   acc = {rem, quot}; restoring step with trial subtract.
module md_iter
  import muldiv_seq_pkg::*;
(
  input  logic             is_div_i,
  input  logic [DW-1:0]    acc_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic [DW-1:0]    acc_o
);

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] diff;

  // One shift-add (multiply) or shift-subtract (divide) step.
  always_comb begin
    add_sum   = {1'b0, acc_i[DW-1:WIDTH]} + (acc_i[0] ? {1'b0, opb_i} : '0);
    rem_shift = acc_i[DW-1:WIDTH-1];
    diff      = {1'b0, rem_shift} - {2'b00, opb_i};
    if (is_div_i) begin
      // The remainder stays below the divisor, so the restored value fits WIDTH bits.
      if (diff[WIDTH+1]) begin
        acc_o = {rem_shift[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end else begin
        acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_o = {add_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
// Operands are latched as magnitudes on Start, 32 iterations run through md_iter,
// then one fixup cycle applies result signs and writes HI/LO.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             IsDiv,
  input  logic             Unsigned,
  input  logic [WIDTH-1:0] Op1,
  input  logic [WIDTH-1:0] Op2,
  input  logic             WrHi,
  input  logic             WrLo,
  input  logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done
);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    acc_q;
  logic [DW-1:0]    acc_d;
  logic [WIDTH-1:0] opb_q;
  logic             is_div_q;
  logic             neg_q;      // product / quotient negate
  logic             neg_rem_q;  // remainder negate (follows dividend sign)
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic             done_q;

  logic [WIDTH-1:0] mag1, mag2;
  logic             sgn1, sgn2;

  logic [DW-1:0]    prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign sgn1 = ~Unsigned & Op1[WIDTH-1];
  assign sgn2 = ~Unsigned & Op2[WIDTH-1];
  assign mag1 = md_abs(Op1, ~Unsigned);
  assign mag2 = md_abs(Op2, ~Unsigned);

  md_iter u_iter (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opb_i    (opb_q),
    .acc_o    (acc_d)
  );

  // Sign fixup of the finished accumulator into HI/LO next values.
  always_comb begin
    prod_fix = neg_q ? ((~acc_q) + DW'(1)) : acc_q;
    quot_fix = neg_q ? ((~acc_q[WIDTH-1:0]) + WIDTH'(1)) : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? ((~acc_q[DW-1:WIDTH]) + WIDTH'(1)) : acc_q[DW-1:WIDTH];
    if (is_div_q) begin
      hi_d = rem_fix;
      lo_d = quot_fix;
    end else begin
      hi_d = prod_fix[DW-1:WIDTH];
      lo_d = prod_fix[WIDTH-1:0];
    end
  end

  // Sequencer FSM: issue, iterate, fix up and write back; owns HI/LO and Done.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        MD_IDLE: begin
          if (WrHi) hi_q <= WrData;
          if (WrLo) lo_q <= WrData;
          if (Start) begin
            is_div_q  <= IsDiv;
            neg_q     <= sgn1 ^ sgn2;
            neg_rem_q <= sgn1;
            // Divide keeps the divisor as the iteration operand; multiply keeps the multiplicand.
            opb_q     <= IsDiv ? mag2 : mag1;
            acc_q     <= {{WIDTH{1'b0}}, (IsDiv ? mag1 : mag2)};
            cnt_q     <= CNT_W'(WIDTH - 1);
            state_q   <= MD_RUN;
          end
        end
        MD_RUN: begin
          acc_q <= acc_d;
          if (cnt_q == '0) begin
            state_q <= MD_FIX;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        MD_FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          done_q  <= 1'b1;
          state_q <= MD_IDLE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign Busy = (state_q != MD_IDLE);
  assign Hi   = hi_q;
  assign Lo   = lo_q;
  assign Done = done_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;

  logic        Clk = 1'b0;
  logic        Reset, Start, IsDiv, Unsigned, WrHi, WrLo;
  logic [31:0] Op1, Op2, WrData;
  logic [31:0] Hi, Lo;
  logic        Busy, Done;

  int checks = 0;
  int errors = 0;

  muldiv_seq dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .IsDiv    (IsDiv),
    .Unsigned (Unsigned),
    .Op1      (Op1),
    .Op2      (Op2),
    .WrHi     (WrHi),
    .WrLo     (WrLo),
    .WrData   (WrData),
    .Hi       (Hi),
    .Lo       (Lo),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural result of MULT/MULTU/DIV/DIVU from plain arithmetic.
  task automatic model(input bit is_div, input bit uns, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] eh, output logic [31:0] el);
    longint      sa, sb, q, r;
    logic [63:0] p;
    logic [31:0] ma;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) begin
      if (uns) p = {32'h0, a} * {32'h0, b};
      else     p = 64'(sa * sb);
      eh = p[63:32];
      el = p[31:0];
    end else if (uns) begin
      if (b == 0) begin
        el = 32'hFFFF_FFFF;
        eh = a;
      end else begin
        el = a / b;
        eh = a % b;
      end
    end else if (b == 0) begin
      ma = a[31] ? (32'h0 - a) : a;
      el = a[31] ? (32'h0 - 32'hFFFF_FFFF) : 32'hFFFF_FFFF;
      eh = a[31] ? (32'h0 - ma) : ma;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      el = q[31:0];
      eh = r[31:0];
    end
  endtask

  // Issue one op from an IDLE cycle and follow it to Done.
  // disturb >= 0 injects Start plus WrLo=0xDEAD that many cycles after issue.
  task automatic run_op(input string tag, input bit is_div, input bit uns,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit wr_hi, input bit wr_lo, input logic [31:0] wdata,
                        input int disturb);
    logic [31:0] eh, el;
    int n, busy_n;
    bit seen;
    model(is_div, uns, a, b, eh, el);
    Start = 1'b1; IsDiv = is_div; Unsigned = uns; Op1 = a; Op2 = b;
    WrHi = wr_hi; WrLo = wr_lo; WrData = wdata;
    @(posedge Clk); #1;
    Start = 1'b0; WrHi = 1'b0; WrLo = 1'b0;
    Op1 = $urandom; Op2 = $urandom; IsDiv = 1'($urandom); Unsigned = 1'($urandom);
    if (wr_hi) check({tag, "_mthi_with_start"}, Hi, wdata);
    if (wr_lo) check({tag, "_mtlo_with_start"}, Lo, wdata);
    busy_n = Busy ? 1 : 0;
    n = 0;
    seen = 0;
    while (n < 60 && !seen) begin
      if (n == disturb) begin
        Start = 1'b1; WrLo = 1'b1; WrData = 32'h0000_DEAD;
        Op1 = $urandom; Op2 = $urandom;
      end
      @(posedge Clk); #1;
      n++;
      Start = 1'b0; WrLo = 1'b0;
      if (Done) seen = 1;
      else if (Busy) busy_n++;
    end
    check({tag, "_latency"}, n, 33);
    check({tag, "_busy_cycles"}, busy_n, 33);
    check({tag, "_hi"}, Hi, eh);
    check({tag, "_lo"}, Lo, el);
  endtask

  task automatic idle_cycle();
    @(posedge Clk); #1;
    check("done_single_pulse", Done, 1'b0);
    check("idle_not_busy", Busy, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dn;
    Reset = 1'b1; Start = 1'b0; IsDiv = 1'b0; Unsigned = 1'b0;
    Op1 = '0; Op2 = '0; WrHi = 1'b0; WrLo = 1'b0; WrData = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_hi", Hi, 32'h0);
    check("reset_lo", Lo, 32'h0);
    check("reset_done", Done, 1'b0);
    check("reset_busy", Busy, 1'b0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    run_op("multu_7x6", 0, 1, 32'd7, 32'd6, 0, 0, 0, -1);            idle_cycle();
    run_op("mult_m3x5", 0, 0, 32'hFFFF_FFFD, 32'd5, 0, 0, 0, -1);     idle_cycle();
    run_op("multu_max", 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, -1); idle_cycle();
    run_op("divu_100_7", 1, 1, 32'd100, 32'd7, 0, 0, 0, -1);          idle_cycle();
    run_op("div_m7_2", 1, 0, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, -1);      idle_cycle();
    run_op("div_ovf", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, -1); idle_cycle();
    run_op("divu_by0", 1, 1, 32'h0000_1234, 32'h0, 0, 0, 0, -1);       idle_cycle();
    run_op("div_neg_by0", 1, 0, 32'hFFFF_FF00, 32'h0, 0, 0, 0, -1);   idle_cycle();
    run_op("multu_3x3_busy", 0, 1, 32'd3, 32'd3, 0, 0, 0, 10);        idle_cycle();

    // Second op issued in the Done cycle of the first.
    run_op("b2b_first", 0, 0, 32'hFFFF_FFF0, 32'd9, 0, 0, 0, -1);
    run_op("b2b_second", 1, 1, 32'd1000, 32'd33, 0, 0, 0, -1);        idle_cycle();

    run_op("mthi_mtlo_start", 1, 0, 32'd77, 32'hFFFF_FFFB, 1, 1, 32'h1357_9BDF, -1);
    idle_cycle();

    for (int i = 0; i < 40; i++) begin
      run_op("rand", 1'($urandom), 1'($urandom), pick(), pick(), 0, 0, 0, -1);
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
    idle_cycle();

    // Abort a DIVU part way through.
    Start = 1'b1; IsDiv = 1'b1; Unsigned = 1'b1; Op1 = 32'd5000; Op2 = 32'd3;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (14) begin
      @(posedge Clk); #1;
    end
    check("abort_busy_before", Busy, 1'b1);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("abort_busy", Busy, 1'b0);
    check("abort_hi", Hi, 32'h0);
    check("abort_lo", Lo, 32'h0);
    check("abort_done", Done, 1'b0);
    dn = 0;
    repeat (40) begin
      @(posedge Clk); #1;
      if (Done) dn++;
    end
    check("abort_no_done", dn, 0);

    WrHi = 1'b1; WrData = 32'h55;
    @(posedge Clk); #1;
    WrHi = 1'b0;
    check("idle_mthi_hi", Hi, 32'h55);
    check("idle_mthi_lo", Lo, 32'h0);
    WrLo = 1'b1; WrData = 32'hA5A5_0001;
    @(posedge Clk); #1;
    WrLo = 1'b0;
    check("idle_mtlo_lo", Lo, 32'hA5A5_0001);
    check("idle_mtlo_hi", Hi, 32'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
